// File: rtl/fit_pipe_arbiter_pkg.sv
// Shared types and constants for the fit pipeline arbiter.
// Holds the drain FSM state encoding, the quality-flag width and the legal
// NREQ/LAT parameter ranges. No ports; imported by fit_pipe_arbiter and fit_tag_delay.
package fit_pipe_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } fit_state_t;

   localparam int QW       = 3;
   localparam int NREQ_MIN = 2;
   localparam int NREQ_MAX = 8;
   localparam int LAT_MIN  = 1;
   localparam int LAT_MAX  = 16;

endpackage

// File: rtl/fit_tag_delay.sv
// Fixed-depth tag delay line that follows the shared fit pipeline.
// Latency: DEPTH clocks from i_d to o_q. No backpressure; it shifts every cycle.
// Ports: i_clock, i_clear (async, active-high, empties every stage), i_d in, o_q out.
module fit_tag_delay
   import fit_pipe_arbiter_pkg::*;
#(
   parameter int W     = 6,
   parameter int DEPTH = 6
) (
   input  logic         i_clock,
   input  logic         i_clear,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_sr [DEPTH];

   always_ff @(posedge i_clock or posedge i_clear) begin
      if (i_clear) begin
         for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
      end else begin
         r_sr[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
   end

   assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/fit_pipe_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency fit pipeline, with a result tag
// line and a flush/drain FSM. Latency: grant at t -> pipe_in at t+1 -> res at t+1+LAT.
// Backpressure: requests are level; an ungranted request (or any in DRAIN/DONE) simply waits.
// Ports: i_clock, i_reset (async active-high); i_req/i_req_data/i_req_quality per requester;
// o_gnt one-hot; o_pipe_in_valid/_data issue; o_res_valid/_id/_quality result tag;
// i_flush, o_flush_done pulse, o_busy entries in flight.
// Build option: define FIT_ARB_PRIO0_EN to give requester 0 absolute priority.
module fit_pipe_arbiter
   import fit_pipe_arbiter_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int DW   = 32,
   parameter  int LAT  = 6,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NREQ-1:0]    i_req,
   input  logic [NREQ*DW-1:0] i_req_data,
   input  logic [NREQ*QW-1:0] i_req_quality,
   output logic [NREQ-1:0]    o_gnt,
   output logic               o_pipe_in_valid,
   output logic [DW-1:0]      o_pipe_in_data,
   output logic               o_res_valid,
   output logic [IDW-1:0]     o_res_id,
   output logic [QW-1:0]      o_res_quality,
   input  logic               i_flush,
   output logic               o_flush_done,
   output logic               o_busy
);

   localparam int TW = 1 + IDW + QW;
   // Up to LAT+1 tags can be outstanding between grant and result.
   localparam int CW = $clog2(LAT + 2);

`ifdef FIT_ARB_PRIO0_EN
   localparam bit PRIO0 = 1'b1;
`else
   localparam bit PRIO0 = 1'b0;
`endif

   fit_state_t      r_state;
   logic            r_flush_done;
   logic [IDW-1:0]  r_ptr;
   logic [CW-1:0]   r_cnt;
   logic            r_pipe_vld;
   logic [DW-1:0]   r_pipe_dat;
   logic [TW-1:0]   r_tag;

   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_gnt_id;
   logic            w_gnt_any;
   logic [DW-1:0]   w_sel_data;
   logic [QW-1:0]   w_sel_qual;
   logic [TW-1:0]   w_tag_out;
   logic            w_res_vld;
   logic [CW-1:0]   w_cnt_next;

   // Round-robin search from r_ptr+1. Walking k downwards lets the nearest
   // requester overwrite farther ones, so no "found" flag is needed.
   // Grant is also masked during reset so nothing is consumed while held.
   always_comb begin
      int idx;
      idx      = 0;
      w_gnt    = '0;
      w_gnt_id = '0;
      if (r_state == ST_RUN && !i_reset) begin
         for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (i_req[idx]) begin
               w_gnt      = '0;
               w_gnt[idx] = 1'b1;
               w_gnt_id   = IDW'(idx);
            end
         end
         if (PRIO0 && i_req[0]) begin
            w_gnt    = NREQ'(1);
            w_gnt_id = '0;
         end
      end
   end

   assign w_gnt_any  = |w_gnt;
   assign w_sel_data = i_req_data[w_gnt_id*DW +: DW];
   assign w_sel_qual = i_req_quality[w_gnt_id*QW +: QW];
   assign w_res_vld  = w_tag_out[TW-1];

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_gnt_any && !w_res_vld)      w_cnt_next = r_cnt + CW'(1);
      else if (!w_gnt_any && w_res_vld) w_cnt_next = r_cnt - CW'(1);
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_ptr      <= IDW'(NREQ - 1);
         r_cnt      <= '0;
         r_pipe_vld <= 1'b0;
         r_pipe_dat <= '0;
         r_tag      <= '0;
      end else begin
         r_cnt      <= w_cnt_next;
         r_pipe_vld <= w_gnt_any;
         if (w_gnt_any) begin
            r_ptr      <= w_gnt_id;
            r_pipe_dat <= w_sel_data;
         end
         // Idle cycles push an all-zero tag so res_id/res_quality read zero.
         r_tag <= w_gnt_any ? {1'b1, w_gnt_id, w_sel_qual} : '0;
      end
   end

   // r_tag is already one stage, so LAT more stages land the tag at t+1+LAT.
   fit_tag_delay #(.W(TW), .DEPTH(LAT)) u_tag_delay (
      .i_clock (i_clock),
      .i_clear (i_reset),
      .i_d     (r_tag),
      .o_q     (w_tag_out)
   );

   // DRAIN looks at the next counter value so DONE follows the last result directly.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_RUN;
         r_flush_done <= 1'b0;
      end else begin
         r_flush_done <= 1'b0;
         case (r_state)
            ST_RUN:   if (i_flush) r_state <= ST_DRAIN;
            ST_DRAIN: if (w_cnt_next == '0) begin
                         r_state      <= ST_DONE;
                         r_flush_done <= 1'b1;
                      end
            ST_DONE:  r_state <= ST_RUN;
            default:  r_state <= ST_RUN;
         endcase
      end
   end

   assign o_gnt           = w_gnt;
   assign o_pipe_in_valid = r_pipe_vld;
   assign o_pipe_in_data  = r_pipe_dat;
   assign o_res_valid     = w_res_vld;
   assign o_res_id        = w_res_vld ? w_tag_out[QW +: IDW] : '0;
   assign o_res_quality   = w_res_vld ? w_tag_out[0 +: QW]   : '0;
   assign o_flush_done    = r_flush_done;
   assign o_busy          = (r_cnt != '0);

endmodule
